// File: rtl/truth_table_sweeper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : netsynth_tt_pkg
//  Description : Shared types and helpers for the truth-table sweeper. It holds
//                the sweep FSM state encoding, the truth-table width helper and
//                the largest supported gate input count.
//  Revision    : 1.0  initial release
// ============================================================================
package netsynth_tt_pkg;

    // Largest gate input count the sweeper supports. 2**6 rows gives a
    // 64-bit code.
    localparam int TT_MAX_N_IN = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } tt_state_e;

    // Width of the truth-table code for an n-input gate.
    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper_if
//  Description : Bundle of the sweep control signals, the gate-side signals
//                and the result signals that connect the sweeper to its
//                environment.
//                  start    : sweep request, accepted only when busy is low
//                  exp_code : expected code, sampled when start is accepted
//                  inp      : gate input drive, inp[N_IN-1] is gate input 1
//                  dut_out  : output of the gate under characterisation
//                  busy     : sweep in progress
//                  done     : one-cycle pulse when the result is published
//                  tt_code  : truth table, row 0 at the MSB
//                  tt_valid : tt_code holds a complete sweep result
//                  match    : tt_code equals the latched expected code
//                The master modport is the environment side and the slave
//                modport is the sweeper side.
//  Revision    : 1.0  initial release
// ============================================================================
interface truth_table_sweeper_if #(
    parameter int N_IN = 3
);
    localparam int TT_W = netsynth_tt_pkg::tt_width(N_IN);

    logic              start;
    logic [TT_W-1:0]   exp_code;
    logic [N_IN-1:0]   inp;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic [TT_W-1:0]   tt_code;
    logic              tt_valid;
    logic              match;

    modport master (
        output start, exp_code, dut_out,
        input  inp, busy, done, tt_code, tt_valid, match
    );

    modport slave (
        input  start, exp_code, dut_out,
        output inp, busy, done, tt_code, tt_valid, match
    );

endinterface
`default_nettype wire

// File: rtl/truth_table_sweeper_row_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tt_row_timer
//  Description : Down-counter that sets the length of the hold window for each
//                truth-table row. load_i reloads SETTLE. dec_i counts down
//                toward zero, and the counter stops at zero. expired_o is high
//                while the count is zero.
//                  clk, rst_n : clock, asynchronous active-low reset
//                  load_i     : reload the window length
//                  dec_i      : count down one step
//                  expired_o  : the window has elapsed
//  Revision    : 1.0  initial release
// ============================================================================
module tt_row_timer #(
    parameter int SETTLE = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic load_i,
    input  wire logic dec_i,
    output logic      expired_o
);

    // A counter of at least 1 bit, so that SETTLE=0 still gives a legal vector.
    localparam int            CW       = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= LOAD_VAL;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Harness stage for one N_IN-input combinational gate. The
//                module drives every input combination in ascending row order.
//                It holds each row for SETTLE+1 cycles and samples the gate at
//                the end of each window. The samples form a truth-table code
//                with row 0 at the MSB, and the code is compared with an
//                expected code that is latched at start.
//                  clk, rst_n : clock, asynchronous active-low reset
//                  bus        : slave side of truth_table_sweeper_if
//  Revision    : 1.0  initial release
// ============================================================================
module truth_table_sweeper
    import netsynth_tt_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    truth_table_sweeper_if.slave  bus
);

    localparam int              TT_W     = tt_width(N_IN);
    localparam logic [N_IN-1:0] ROW_LAST = '1;

    tt_state_e         state_q;
    logic [N_IN-1:0]   row_q;
    logic [N_IN-1:0]   inp_q;
    logic [TT_W-1:0]   sr_q;
    logic [TT_W-1:0]   exp_q;
    logic [TT_W-1:0]   tt_code_q;
    logic              busy_q;
    logic              done_q;
    logic              tt_valid_q;
    logic              match_q;

    logic              timer_expired;
    logic              timer_load;
    logic              timer_dec;
    logic              accept;
    logic              last_row;

    // busy is always low in IDLE, so the state alone qualifies start.
    assign accept   = (state_q == IDLE) && bus.start;
    assign last_row = (row_q == ROW_LAST);

    // The window is reloaded when a sweep starts and again each time a row
    // is sampled, except after the last row.
    assign timer_load = accept ||
                        ((state_q == HOLD) && timer_expired && !last_row);
    assign timer_dec  = (state_q == HOLD) && !timer_expired;

    tt_row_timer #(
        .SETTLE (SETTLE)
    ) u_row_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (timer_load),
        .dec_i     (timer_dec),
        .expired_o (timer_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_q      <= '0;
            inp_q      <= '0;
            sr_q       <= '0;
            exp_q      <= '0;
            tt_code_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_valid_q <= 1'b0;
            match_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= HOLD;
                        busy_q     <= 1'b1;
                        tt_valid_q <= 1'b0;
                        inp_q      <= '0;
                        row_q      <= '0;
                        sr_q       <= '0;
                        exp_q      <= bus.exp_code;
                    end
                end
                HOLD: begin
                    if (timer_expired) begin
                        sr_q <= {sr_q[TT_W-2:0], bus.dut_out};
                        if (last_row) begin
                            state_q <= DONE;
                            inp_q   <= '0;
                        end else begin
                            row_q <= row_q + 1'b1;
                            inp_q <= row_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    // The result is published only here, so a partial code
                    // never reaches tt_code.
                    state_q    <= IDLE;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    tt_code_q  <= sr_q;
                    tt_valid_q <= 1'b1;
                    match_q    <= (sr_q == exp_q);
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.inp      = inp_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tt_code  = tt_code_q;
    assign bus.tt_valid = tt_valid_q;
    assign bus.match    = match_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_truth_table_sweeper
//  Description : Self-checking bench for truth_table_sweeper. Instance A uses
//                the default parameters and drives a gate that the bench can
//                select. Instance B uses N_IN=2 and SETTLE=0 and drives a
//                2-input OR gate.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_err = 0;

    truth_table_sweeper_if #(.N_IN(3)) ifa ();
    truth_table_sweeper_if #(.N_IN(2)) ifb ();

    truth_table_sweeper #(.N_IN(3), .SETTLE(2)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
    );

    truth_table_sweeper #(.N_IN(2), .SETTLE(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate model for instance A. Mode 0 is NAND, 1 is XOR, 2 is AND and 3 is
    // OR. Any other mode looks up a free truth table whose row 0 is at the MSB.
    int         mode_a = 0;
    logic [7:0] tbl_a  = 8'h00;

    function automatic logic gate3(input int mode, input logic [2:0] x,
                                   input logic [7:0] tbl);
        int idx;
        idx = 7 - int'(x);
        case (mode)
            0:       return ~&x;
            1:       return ^x;
            2:       return &x;
            3:       return |x;
            default: return tbl[idx];
        endcase
    endfunction

    assign ifa.dut_out = gate3(mode_a, ifa.inp, tbl_a);
    assign ifb.dut_out = |ifb.inp;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Runs one full sweep on instance A and checks its timing and result.
    // The task is entered and left on a falling edge.
    task automatic sweep_a(input string tag, input int mode, input logic [7:0] tbl,
                           input logic [7:0] exp, input logic [7:0] want_code,
                           input logic want_match);
        int lat;
        mode_a        = mode;
        tbl_a         = tbl;
        ifa.exp_code  = exp;
        ifa.start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.start    = 1'b0;
        ifa.exp_code = ~exp;   // the value latched at accept must be the one used
        check({tag, " busy_after_accept"}, 64'(ifa.busy), 64'd1);
        check({tag, " tt_valid_after_accept"}, 64'(ifa.tt_valid), 64'd0);
        lat = 0;
        while (ifa.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " done_latency"}, 64'(lat), 64'd25);
        check({tag, " tt_code"}, 64'(ifa.tt_code), 64'(want_code));
        check({tag, " match"}, 64'(ifa.match), 64'(want_match));
        check({tag, " tt_valid"}, 64'(ifa.tt_valid), 64'd1);
        check({tag, " busy_at_done"}, 64'(ifa.busy), 64'd0);
        @(negedge clk);
        check({tag, " done_pulse_width"}, 64'(ifa.done), 64'd0);
    endtask

    typedef struct {
        string      name;
        int         mode;
        logic [7:0] tbl;
        logic [7:0] exp;
        logic [7:0] want_code;
        logic       want_match;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] inp_seq [5];
        int         lat;
        int         extra_done;
        logic [7:0] rt;
        logic [7:0] rexp;

        vecs[0] = '{"nand3", 0, 8'h00, 8'd254, 8'hFE, 1'b1};
        vecs[1] = '{"xor3",  1, 8'h00, 8'd254, 8'h69, 1'b0};
        vecs[2] = '{"and3",  2, 8'h00, 8'h01,  8'h01, 1'b1};
        vecs[3] = '{"or3",   3, 8'h00, 8'h7F,  8'h7F, 1'b1};
        vecs[4] = '{"or3_x", 3, 8'h00, 8'h80,  8'h7F, 1'b0};
        vecs[5] = '{"tblA5", 4, 8'hA5, 8'hA5,  8'hA5, 1'b1};

        inp_seq[0] = 2'd0; inp_seq[1] = 2'd1; inp_seq[2] = 2'd2;
        inp_seq[3] = 2'd3; inp_seq[4] = 2'd0;

        rst_n        = 1'b0;
        ifa.start    = 1'b0;
        ifa.exp_code = 8'h00;
        ifb.start    = 1'b0;
        ifb.exp_code = 4'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy", 64'(ifa.busy), 64'd0);
        check("rst done", 64'(ifa.done), 64'd0);
        check("rst inp", 64'(ifa.inp), 64'd0);
        check("rst tt_code", 64'(ifa.tt_code), 64'd0);
        check("rst tt_valid", 64'(ifa.tt_valid), 64'd0);
        check("rst match", 64'(ifa.match), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed-gate vector table
        for (int i = 0; i < 6; i++) begin
            sweep_a(vecs[i].name, vecs[i].mode, vecs[i].tbl, vecs[i].exp,
                    vecs[i].want_code, vecs[i].want_match);
        end

        // Random gates: the reference code is the gate's own table read
        // with row 0 first.
        for (int i = 0; i < 12; i++) begin
            rt   = 8'($urandom);
            rexp = ($urandom_range(0, 1) == 1) ? rt : 8'($urandom);
            sweep_a($sformatf("rand%0d", i), 4, rt, rexp, rt, rexp == rt);
        end

        // SETTLE=0, N_IN=2, OR2: one row per cycle
        ifb.exp_code = 4'h7;
        ifb.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifb.start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("s0 inp[%0d]", k), 64'(ifb.inp), 64'(inp_seq[k]));
            check($sformatf("s0 nodone[%0d]", k), 64'(ifb.done), 64'd0);
            @(negedge clk);
        end
        check("s0 done", 64'(ifb.done), 64'd1);
        check("s0 tt_code", 64'(ifb.tt_code), 64'h7);
        check("s0 match", 64'(ifb.match), 64'd1);

        // A start pulse during a sweep, with a different exp_code, is ignored.
        mode_a       = 0;
        ifa.exp_code = 8'hFE;
        ifa.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (4) @(negedge clk);
        ifa.exp_code = 8'h00;
        ifa.start    = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        lat = 5;
        while (ifa.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("restart done_latency", 64'(lat), 64'd25);
        check("restart tt_code", 64'(ifa.tt_code), 64'hFE);
        check("restart match", 64'(ifa.match), 64'd1);
        extra_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) extra_done++;
        end
        check("restart extra_done", 64'(extra_done), 64'd0);

        // Reset asserted mid-sweep
        sweep_a("pre_rst", 1, 8'h00, 8'h69, 8'h69, 1'b1);
        mode_a       = 1;
        ifa.exp_code = 8'h69;
        ifa.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst inp_before", 64'(ifa.inp), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", 64'(ifa.busy), 64'd0);
        check("midrst inp", 64'(ifa.inp), 64'd0);
        check("midrst tt_valid", 64'(ifa.tt_valid), 64'd0);
        check("midrst tt_code", 64'(ifa.tt_code), 64'd0);
        check("midrst match", 64'(ifa.match), 64'd0);
        check("midrst done", 64'(ifa.done), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ifa.done === 1'b1) extra_done++;
        end
        check("midrst no_done", 64'(extra_done), 64'd0);
        sweep_a("post_rst", 0, 8'h00, 8'hFE, 8'hFE, 1'b1);

        // start held high: sweeps run back to back.
        mode_a       = 0;
        ifa.exp_code = 8'hFE;
        ifa.start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat        = 0;
        extra_done = 0;
        while (ifa.done !== 1'b1 && lat < 100) begin
            if (ifa.tt_valid !== 1'b0) extra_done++;
            @(negedge clk);
            lat++;
        end
        check("b2b first_latency", 64'(lat), 64'd25);
        check("b2b tt_valid_low_during", 64'(extra_done), 64'd0);
        check("b2b first_code", 64'(ifa.tt_code), 64'hFE);
        check("b2b idle_gap_busy", 64'(ifa.busy), 64'd0);
        @(negedge clk);
        check("b2b reaccept_busy", 64'(ifa.busy), 64'd1);
        check("b2b reaccept_tt_valid", 64'(ifa.tt_valid), 64'd0);
        ifa.start = 1'b0;
        lat = 0;
        while (ifa.done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("b2b second_latency", 64'(lat), 64'd25);
        check("b2b second_match", 64'(ifa.match), 64'd1);
        repeat (30) @(negedge clk);
        check("b2b no_third", 64'(ifa.busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
